dual_grant_sequencer: RTL and testbench

- Receive end of the dual-priority-encoder interface: accepts an encoded (first, second) request-index pair and decodes it back into one-hot 12-bit grants.
- Grants are issued sequentially, first-priority then second-priority, each held for a programmable number of cycles.
- Also presents the reconstructed two-hot request mask for the transaction.
- Sits between the arbitration encoder and the 12 requesters' grant lines.

---
 rtl/dual_grant_sequencer_pkg.sv | 20 ++
 rtl/dual_grant_sequencer_index_decoder.sv | 19 +
 rtl/dual_grant_sequencer.sv | 136 +++++++++++++
 tb/tb_dual_grant_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dual_grant_sequencer_pkg.sv
// Shared types and helpers for the dual-grant sequencer: state encoding,
// request-line count default, index code width and the code legality check.
package dual_grant_pkg;

  localparam int N_REQ_DEF = 12;
  localparam int CODE_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    G_FIRST,
    G_SECOND,
    FIN
  } state_t;

  // Zero is a legal "no request" code; anything past the last line is not.
  function automatic logic code_legal(input logic [CODE_W-1:0] code, input int nreq);
    return int'(code) <= nreq;
  endfunction

endpackage

// File: rtl/dual_grant_sequencer_index_decoder.sv
// Combinational index-code to one-hot decoder: code k selects line k-1,
// zero and out-of-range codes give an all-zero vector.
module index_decoder
  import dual_grant_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      onehot[i] = (int'(code) == i + 1);
    end
  end

endmodule

// File: rtl/dual_grant_sequencer.sv
// Receive side of the dual-priority-encoder link: accepts a (first, second)
// index pair and replays it as back-to-back one-hot grants of fixed length.
module dual_grant_sequencer
  import dual_grant_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] first,
  input  logic [CODE_W-1:0] second,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  mask,
  output logic              busy,
  output logic              done,
  output logic              code_err
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t            state;
  logic [CODE_W-1:0] first_q;
  logic [CODE_W-1:0] second_q;
  logic [7:0]        cnt;

  logic              first_ok;
  logic              second_ok;
  logic [CODE_W-1:0] first_s;
  logic [CODE_W-1:0] second_s;
  logic [CODE_W-1:0] first_dec_in;
  logic [CODE_W-1:0] second_dec_in;
  logic [N_REQ-1:0]  first_hot;
  logic [N_REQ-1:0]  second_hot;

  // Illegal codes collapse to "none" and a repeated second code is dropped.
  // While idle the decoders look at the incoming pair, otherwise at the
  // latched pair, so the same two decoders serve both mask and grants.
  always_comb begin
    first_ok      = code_legal(first, N_REQ);
    second_ok     = code_legal(second, N_REQ);
    first_s       = first_ok ? first : '0;
    second_s      = (second_ok && (second != first_s)) ? second : '0;
    first_dec_in  = (state == IDLE) ? first_s  : first_q;
    second_dec_in = (state == IDLE) ? second_s : second_q;
  end

  index_decoder #(.N_REQ(N_REQ)) u_dec_first (
    .code   (first_dec_in),
    .onehot (first_hot)
  );

  index_decoder #(.N_REQ(N_REQ)) u_dec_second (
    .code   (second_dec_in),
    .onehot (second_hot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      first_q  <= '0;
      second_q <= '0;
      cnt      <= '0;
      in_ready <= 1'b0;
      grant    <= '0;
      mask     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      code_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      code_err <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            first_q  <= first_s;
            second_q <= second_s;
            cnt      <= HOLD_LOAD;
            mask     <= first_hot | second_hot;
            code_err <= !first_ok || !second_ok;
            if (first_s != '0) begin
              state <= G_FIRST;
              grant <= first_hot;
              busy  <= 1'b1;
            end else if (second_s != '0) begin
              state <= G_SECOND;
              grant <= second_hot;
              busy  <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        G_FIRST: begin
          if (cnt == '0) begin
            if (second_q != '0) begin
              state <= G_SECOND;
              cnt   <= HOLD_LOAD;
              grant <= second_hot;
            end else begin
              state <= FIN;
              grant <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        G_SECOND: begin
          if (cnt == '0) begin
            state <= FIN;
            grant <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        FIN: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_grant_sequencer.sv
// Scoreboard bench for dual_grant_sequencer: directed pairs push expected
// grant sequences, an independent monitor reconstructs and compares them.
module tb_dual_grant_sequencer;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  first = '0;
  logic [3:0]  second = '0;
  logic [11:0] grant;
  logic [11:0] mask;
  logic        busy;
  logic        done;
  logic        code_err;

  always #5 clk = ~clk;

  dual_grant_sequencer #(.N_REQ(12), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .first    (first),
    .second   (second),
    .grant    (grant),
    .mask     (mask),
    .busy     (busy),
    .done     (done),
    .code_err (code_err)
  );

  typedef struct {
    logic [11:0] g1;
    logic [11:0] g2;
    logic [11:0] mask;
    int          lat;
    int          errs;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one pair at a negedge and hold it until it has been accepted.
  task automatic applyStimulus(input logic [3:0] f, input logic [3:0] s,
                               input logic [11:0] g1, input logic [11:0] g2,
                               input logic [11:0] m, input int errs, input bit track);
    exp_t e;
    bit   taken;
    e.g1   = g1;
    e.g2   = g2;
    e.mask = m;
    e.errs = errs;
    e.lat  = (int'(g1 != 0) + int'(g2 != 0)) * HOLD + 1;
    if (track) expq.push_back(e);
    first    = f;
    second   = s;
    in_valid = 1'b1;
    taken    = 1'b0;
    for (int i = 0; i < 100 && !taken; i++) begin
      if (in_ready) taken = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("accept", 32'(taken), 1);
    if (!taken && track) void'(expq.pop_back());
  endtask

  // Monitor: samples shortly after each falling edge, rebuilds the grant
  // segments of the live transaction and scores them when done pulses.
  bit          active = 1'b0;
  bit          extra;
  int          cnt;
  int          nseg;
  int          errs;
  logic [11:0] segval [2];
  int          seglen [2];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        active = 1'b0;
        continue;
      end
      if (active) begin
        cnt++;
        checkOutput("busy_vs_grant", 32'(busy), 32'(grant != 0));
        checkOutput("grant_onehot0", 32'($onehot0(grant)), 1);
        if (grant != 0) begin
          if (nseg > 0 && grant == segval[nseg-1]) seglen[nseg-1]++;
          else if (nseg < 2) begin
            segval[nseg] = grant;
            seglen[nseg] = 1;
            nseg++;
          end else extra = 1'b1;
        end
        if (code_err) errs++;
        if (done) begin
          checkOutput("expect_available", 32'(expq.size() != 0), 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            checkOutput("latency", cnt, e.lat);
            checkOutput("grant1", 32'(segval[0]), 32'(e.g1));
            checkOutput("grant1_len", seglen[0], (e.g1 != 0) ? HOLD : 0);
            checkOutput("grant2", 32'(segval[1]), 32'(e.g2));
            checkOutput("grant2_len", seglen[1], (e.g2 != 0) ? HOLD : 0);
            checkOutput("extra_segment", 32'(extra), 0);
            checkOutput("mask", 32'(mask), 32'(e.mask));
            checkOutput("code_err_pulses", errs, e.errs);
            checkOutput("grant_at_done", 32'(grant), 0);
          end
          active = 1'b0;
        end
      end else begin
        checkOutput("stray_done", 32'(done), 0);
      end
      if (in_valid && in_ready) begin
        active    = 1'b1;
        extra     = 1'b0;
        cnt       = 0;
        nseg      = 0;
        errs      = 0;
        segval[0] = '0;
        segval[1] = '0;
        seglen[0] = 0;
        seglen[1] = 0;
      end
    end
  end

  initial begin
    bit seen;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 0);
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_mask", 32'(mask), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_code_err", 32'(code_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(in_ready), 1);

    applyStimulus(4'd12, 4'd11, 12'h800, 12'h400, 12'hC00, 0, 1'b1);
    applyStimulus(4'd2,  4'd1,  12'h002, 12'h001, 12'h003, 0, 1'b1);
    applyStimulus(4'd3,  4'd0,  12'h004, 12'h000, 12'h004, 0, 1'b1);
    applyStimulus(4'd0,  4'd0,  12'h000, 12'h000, 12'h000, 0, 1'b1);
    applyStimulus(4'd14, 4'd5,  12'h010, 12'h000, 12'h010, 1, 1'b1);
    applyStimulus(4'd7,  4'd7,  12'h040, 12'h000, 12'h040, 0, 1'b1);
    applyStimulus(4'd4,  4'd15, 12'h008, 12'h000, 12'h008, 1, 1'b1);

    // Junk pair held valid for the whole sequence must never be taken.
    first    = 4'd9;
    second   = 4'd10;
    in_valid = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else checkOutput("ready_while_busy", 32'(in_ready), 0);
    end
    checkOutput("hold_done_seen", 32'(seen), 1);
    applyStimulus(4'd6, 4'd8, 12'h020, 12'h080, 12'h0A0, 0, 1'b1);

    // Reset two cycles into the second grant; this pair never completes.
    applyStimulus(4'd2, 4'd1, 12'h002, 12'h001, 12'h003, 0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_grant", 32'(grant), 32'h001);
    rst = 1'b1;
    #1;
    checkOutput("midrst_grant", 32'(grant), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_done", 32'(done), 0);
    checkOutput("midrst_in_ready", 32'(in_ready), 0);
    checkOutput("midrst_mask", 32'(mask), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_midrst", 32'(in_ready), 1);
    checkOutput("no_done_after_midrst", 32'(done), 0);

    applyStimulus(4'd1, 4'd12, 12'h001, 12'h800, 12'h801, 0, 1'b1);

    for (int i = 0; i < 100 && expq.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(expq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
